// File: rtl/pspin_ingress_dma_burst.sv
// Ingress DMA: writes AXIS frames into allocator-provided buffers as AXI4 INCR
// bursts, then reports {error,tag,bytes,addr} to the HER generator.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   s_desc_*                       {tag,len,addr} descriptors from allocator
//   s_axis_*                       incoming frame stream (tkeep contiguous)
//   m_axi_aw* / m_axi_w* / m_axi_b*  AXI4 write channels (one burst in flight)
//   m_cmpl_*                       completion record {err,tag,bytes,addr}
module pspin_ingress_dma_burst #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 32,
    parameter int MAX_BURST_BEATS = 16,
    parameter int DESC_FIFO_DEPTH = 4,
    localparam int KEEP_WIDTH     = DATA_WIDTH / 8,
    localparam int DW             = TAG_WIDTH + LEN_WIDTH + ADDR_WIDTH,
    localparam int CW             = 2 + DW
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DW-1:0]         s_desc_data,
    input  logic                  s_desc_valid,
    output logic                  s_desc_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [KEEP_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [CW-1:0]         m_cmpl_data,
    output logic                  m_cmpl_valid,
    input  logic                  m_cmpl_ready
);

    localparam int OFF  = $clog2(KEEP_WIDTH);
    localparam int PW   = $clog2(DESC_FIFO_DEPTH);
    localparam int RW   = LEN_WIDTH + 1;
    localparam int BW   = 9;
    localparam int CNTW = $clog2(KEEP_WIDTH + 1);

    localparam logic [1:0]    ERR_OK    = 2'd0;
    localparam logic [1:0]    ERR_TRUNC = 2'd1;
    localparam logic [1:0]    ERR_BUS   = 2'd2;
    localparam logic [PW:0]   PONE      = 1;
    localparam logic [BW-1:0] BONE      = 1;

    typedef enum logic [2:0] {
        IDLE, AW, DATA, RESP, DRAIN, CMPL
    } state_t;

    state_t state, state_n;

    // descriptor queue; pointers carry an extra wrap bit
    logic [DW-1:0] mem [DESC_FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic          addr_lsb_unused;

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign s_desc_ready = rstn && !full;
    assign push  = s_desc_valid && s_desc_ready;
    assign pop   = (state == IDLE) && !empty;
    assign addr_lsb_unused = ^s_desc_data[OFF-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE;
            if (pop)  rd_ptr <= rd_ptr + PONE;
        end
    end

    // buffers are beat aligned: sub-beat address bits are dropped on entry
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {s_desc_data[DW-1:OFF], {OFF{1'b0}}};
        end
    end

    logic [DW-1:0]         head;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [LEN_WIDTH-1:0]  h_len;
    logic [TAG_WIDTH-1:0]  h_tag;
    logic [RW-1:0]         h_beats;

    assign head    = mem[rd_ptr[PW-1:0]];
    assign h_addr  = head[ADDR_WIDTH-1:0];
    assign h_len   = head[ADDR_WIDTH +: LEN_WIDTH];
    assign h_tag   = head[DW-1 -: TAG_WIDTH];
    assign h_beats = ({1'b0, h_len} + RW'(KEEP_WIDTH - 1)) >> OFF;

    logic [ADDR_WIDTH-1:0] base_addr, cur_addr;
    logic [RW-1:0]         rem_beats;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [LEN_WIDTH-1:0]  bytes_q;
    logic [1:0]            err_q;
    logic [BW-1:0]         burst_q, beat_cnt;
    logic                  frame_done;

    // burst size: capped by max burst, remaining beats and 4 KB page
    logic [12:0]   page_beats;
    logic [BW-1:0] cap, burst_w;

    always_comb begin
        page_beats = (13'd4096 - {1'b0, cur_addr[11:0]}) >> OFF;
        cap = BW'(MAX_BURST_BEATS);
        if (page_beats < 13'(cap)) cap = page_beats[BW-1:0];
        burst_w = (rem_beats < RW'(cap)) ? rem_beats[BW-1:0] : cap;
    end

    assign m_axi_awaddr = cur_addr;
    assign m_axi_awlen  = burst_w[7:0] - 8'd1;

    logic [CNTW-1:0] keep_cnt;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + CNTW'(s_axis_tkeep[i]);
        end
    end

    logic last_beat;
    assign last_beat = (beat_cnt == burst_q - BONE);

    always_comb begin
        state_n       = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        s_axis_tready = 1'b0;
        m_cmpl_valid  = 1'b0;
        m_cmpl_data   = '0;
        unique case (state)
            IDLE: begin
                if (pop) state_n = (h_len == '0) ? DRAIN : AW;
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_n = DATA;
            end
            DATA: begin
                m_axi_wlast = last_beat;
                if (frame_done) begin
                    // frame ended early: pad out the committed burst
                    m_axi_wvalid = 1'b1;
                end else begin
                    m_axi_wvalid  = s_axis_tvalid;
                    s_axis_tready = m_axi_wready;
                    m_axi_wdata   = s_axis_tdata;
                    m_axi_wstrb   = s_axis_tkeep;
                end
                if (m_axi_wvalid && m_axi_wready && last_beat) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (frame_done)          state_n = CMPL;
                    else if (rem_beats != 0) state_n = AW;
                    else                     state_n = DRAIN;
                end
            end
            DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_n = CMPL;
            end
            CMPL: begin
                m_cmpl_valid = 1'b1;
                m_cmpl_data  = {err_q, tag_q, bytes_q, base_addr};
                if (m_cmpl_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            base_addr  <= '0;
            cur_addr   <= '0;
            rem_beats  <= '0;
            tag_q      <= '0;
            bytes_q    <= '0;
            err_q      <= ERR_OK;
            burst_q    <= '0;
            beat_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        base_addr  <= h_addr;
                        cur_addr   <= h_addr;
                        rem_beats  <= h_beats;
                        tag_q      <= h_tag;
                        bytes_q    <= '0;
                        err_q      <= (h_len == '0) ? ERR_TRUNC : ERR_OK;
                        frame_done <= 1'b0;
                    end
                end
                AW: begin
                    if (m_axi_awready) begin
                        burst_q  <= burst_w;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (!frame_done && s_axis_tvalid && m_axi_wready) begin
                        bytes_q <= bytes_q + LEN_WIDTH'(keep_cnt);
                        if (s_axis_tlast) frame_done <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        beat_cnt <= beat_cnt + BONE;
                        if (last_beat) begin
                            rem_beats <= rem_beats - RW'(burst_q);
                            cur_addr  <= cur_addr +
                                         (ADDR_WIDTH'(burst_q) << OFF);
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'd0) begin
                            err_q <= ERR_BUS;
                        end else if (!frame_done && rem_beats == 0 &&
                                     err_q != ERR_BUS) begin
                            err_q <= ERR_TRUNC;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pspin_ingress_dma_burst.md
PSPIN_INGRESS_DMA_BURST -- requirements
Module: pspin_ingress_dma_burst

Interface
REQ-001 DATA_WIDTH, 512, AXI and AXIS data width in bits; KEEP_WIDTH = DATA_WIDTH/8 (derived).
REQ-002 ADDR_WIDTH, 32, AXI address width.
REQ-003 LEN_WIDTH, 20, byte-length width.
REQ-004 TAG_WIDTH, 32, allocator tag width.
REQ-005 MAX_BURST_BEATS, 16, maximum AXI burst length in beats (1..256).
REQ-006 DESC_FIFO_DEPTH, 4, descriptor queue depth (power of 2, >=2).
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 s_desc_data  in  TAG+LEN+ADDR  {tag,len,addr} from packet allocator.
REQ-010 s_desc_valid  in  1  / s_desc_ready  out  1  descriptor handshake.
REQ-011 s_axis_tdata  in  DATA_WIDTH  frame data.
REQ-012 s_axis_tkeep  in  KEEP_WIDTH  byte enables, contiguous from bit 0.
REQ-013 s_axis_tlast  in  1  end of frame.
REQ-014 s_axis_tvalid  in  1  / s_axis_tready  out  1  stream handshake.
REQ-015 m_axi_awaddr  out  ADDR_WIDTH  burst start address.
REQ-016 m_axi_awlen  out  8  burst beats minus 1.
REQ-017 m_axi_awvalid  out  1  / m_axi_awready  in  1.
REQ-018 m_axi_wdata  out  DATA_WIDTH; m_axi_wstrb  out  KEEP_WIDTH.
REQ-019 m_axi_wlast  out  1; m_axi_wvalid  out  1  / m_axi_wready  in  1.
REQ-020 m_axi_bresp  in  2; m_axi_bvalid  in  1  / m_axi_bready  out  1.
REQ-021 m_cmpl_data  out  2+TAG+LEN+ADDR  {error,tag,len,addr} to HER generator.
REQ-022 m_cmpl_valid  out  1  / m_cmpl_ready  in  1.
REQ-023 AWSIZE = log2(KEEP_WIDTH), AWBURST = INCR and AWID = 0 are tied at the top level, not driven by this block.

Function
REQ-024 Descriptor FIFO: s_desc_ready = not full; push on valid&&ready; addr low log2(KEEP_WIDTH) bits are forced to 0; beats = ceil(len/KEEP_WIDTH).
REQ-025 FSM states: IDLE, AW, DATA, RESP, DRAIN, CMPL; one burst outstanding; strict frame/descriptor order.
REQ-026 IDLE: s_axis_tready=0; if FIFO non-empty, pop, load base/cur addr, rem_beats, tag, bytes=0, err=0, then go to AW (awvalid asserted the cycle after the pop); a desc with len=0 sets err=TRUNC and goes to DRAIN.
REQ-027 AW: burst = min(MAX_BURST_BEATS, rem_beats, (4096-cur_addr[11:0])/KEEP_WIDTH); awvalid held with stable fields until awready; then DATA.
REQ-028 DATA, frame open: wvalid=tvalid, tready=wready, wdata=tdata, wstrb=tkeep; bytes += popcount(tkeep) per accepted beat.
REQ-029 DATA, after tlast accepted mid-burst: remaining beats padded with wvalid=1, wstrb=0, wdata=0, tready=0.
REQ-030 wlast on final beat of each burst; after it: rem_beats -= burst, cur_addr += burst*KEEP_WIDTH, then RESP.
REQ-031 RESP: bready=1; on bvalid with bresp!=0, err=BUS.
REQ-032 After RESP: if frame ended -> CMPL; else if rem_beats>0 -> AW; else err=TRUNC (unless BUS) -> DRAIN.
REQ-033 tlast on the last allocated beat is not truncation.
REQ-034 DRAIN: tready=1, data discarded, no W beats; on tlast accepted -> CMPL.
REQ-035 CMPL: cmpl_valid=1, data={err,tag,bytes,base addr}, held stable until ready; then IDLE; no new pop while in CMPL.
REQ-036 Error codes: 0 OK, 1 TRUNC, 2 BUS; BUS overrides TRUNC.
REQ-037 Bytes reported never exceed beats*KEEP_WIDTH; counter is LEN_WIDTH bits wide.

Reset
REQ-038 While rstn=0: state IDLE, FIFO empty, awvalid/wvalid/wlast/bready/s_axis_tready/m_cmpl_valid=0, m_cmpl_data=0; s_desc_ready=0 during reset and 1 on the first cycle after reset; a reset mid-frame abandons the burst with no completion.

Verification (KEEP_WIDTH=64)
REQ-039 desc addr 0x1000 len 1500, 1500 B frame -> bursts 16 beats @0x1000 and 8 beats @0x1400; cmpl len 1500 err 0.
REQ-040 desc addr 0x1F80 len 256, 256 B frame -> bursts 2 beats @0x1F80 and 2 beats @0x2000 (4 KB split).
REQ-041 desc len 1024, 100 B frame -> one 16-beat burst, beats 3..16 wstrb 0; cmpl len 100 err 0.
REQ-042 desc len 128, 300 B frame -> 2 beats written, 3 beats drained; cmpl len 128 err 1; next frame is handled correctly.
REQ-043 bresp=SLVERR on a burst -> err 2; cmpl_ready low 10 cycles -> cmpl held stable and no pop; 4 descs pushed -> s_desc_ready=0 until the next pop.
